// File: rtl/deserializer_pkg.sv
// -----------------------------------------------------------------------------
// deserializer_pkg
// Shared definitions for the word-stream / frame converters. The serializer
// and the deserializer both import this package, so both ends agree on one
// frame layout: lane k of a frame lives in slice k.
// Contents:
//   LANES_DEF, WIDTH_DEF : default frame geometry
//   word_t, frame_t      : word and frame types at the default geometry
//   word_kind_e          : what an accepted input word does to the frame
// -----------------------------------------------------------------------------
package deserializer_pkg;

  localparam int LANES_DEF = 4;
  localparam int WIDTH_DEF = 16;

  typedef logic [WIDTH_DEF-1:0] word_t;
  typedef word_t [LANES_DEF-1:0] frame_t;

  // Classification of one input cycle.
  typedef enum logic [2:0] {
    KIND_NONE     = 3'd0,  // no word accepted
    KIND_STORE    = 3'd1,  // word goes into a shadow lane
    KIND_COMPLETE = 3'd2,  // last lane: frame moves to the output register
    KIND_RESYNC   = 3'd3,  // sof in mid-frame: restart frame at this word
    KIND_DROP     = 3'd4   // non-sof word while waiting for sof: discard
  } word_kind_e;

endpackage

// File: rtl/deserializer_if.sv
// -----------------------------------------------------------------------------
// deserializer_if
// Bundles the input word stream, the output frame handshake and the framing
// error status of the deserializer.
//   in_valid/in_sof/in_data/in_ready : word stream (lane 0 flagged by in_sof)
//   out_valid/out_data/out_ready     : assembled frame, lane k in slice k
//   err_sync/drop_cnt                : framing error pulse and saturating count
// Modports:
//   master : the environment (word producer and frame consumer)
//   slave  : the deserializer itself
// -----------------------------------------------------------------------------
interface deserializer_if
  import deserializer_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int WIDTH = WIDTH_DEF
) ();

  logic                         in_valid;
  logic                         in_sof;
  logic [WIDTH-1:0]             in_data;
  logic                         in_ready;
  logic                         out_valid;
  logic [LANES-1:0][WIDTH-1:0]  out_data;
  logic                         out_ready;
  logic                         err_sync;
  logic [7:0]                   drop_cnt;

  modport master (
    output in_valid, in_sof, in_data, out_ready,
    input  in_ready, out_valid, out_data, err_sync, drop_cnt
  );

  modport slave (
    input  in_valid, in_sof, in_data, out_ready,
    output in_ready, out_valid, out_data, err_sync, drop_cnt
  );

endinterface

// File: rtl/deserializer.sv
// -----------------------------------------------------------------------------
// deserializer
// Collects LANES consecutive words of WIDTH bits into one frame. Lanes
// 0..LANES-2 are parked in shadow registers; when the last lane is accepted
// the whole frame is copied into the output register in the same edge, so
// out_valid rises one cycle after the last word and back-to-back frames need
// no bubble. Only the last lane is ever back-pressured, and only while the
// previous frame is still waiting for the consumer.
// Framing errors (sof in mid-frame, or a non-sof word while waiting for sof)
// produce a registered one-cycle err_sync pulse and bump a saturating drop_cnt.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : deserializer_if.slave (word input, frame output, error status)
// -----------------------------------------------------------------------------
module deserializer
  import deserializer_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  deserializer_if.slave  bus
);

  localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LANES - 1);

  logic [CNT_W-1:0]             cnt_r, cnt_s;
  logic [LANES-1:0][WIDTH-1:0]  shadow_r, shadow_s;
  logic [LANES-1:0][WIDTH-1:0]  out_data_r, out_data_s;
  logic                         out_valid_r, out_valid_s;
  logic                         err_sync_r, err_sync_s;
  logic [7:0]                   drop_cnt_r, drop_cnt_s;
  logic                         in_ready_s;
  word_kind_e                   kind_s;

  // Acceptance: only the last lane can be blocked, and only by a stalled frame.
  always_comb begin
    in_ready_s = (cnt_r != LAST) || !out_valid_r || bus.out_ready;
  end

  // Classify the current cycle; sof misuse takes priority over completion.
  always_comb begin
    kind_s = KIND_NONE;
    if (bus.in_valid && in_ready_s) begin
      if (bus.in_sof && (cnt_r != '0)) begin
        kind_s = KIND_RESYNC;
      end else if (!bus.in_sof && (cnt_r == '0)) begin
        kind_s = KIND_DROP;
      end else if (cnt_r == LAST) begin
        kind_s = KIND_COMPLETE;
      end else begin
        kind_s = KIND_STORE;
      end
    end else begin
      kind_s = KIND_NONE;
    end
  end

  // Next-state logic for lane counter, shadow lanes, output frame and errors.
  always_comb begin
    cnt_s       = cnt_r;
    shadow_s    = shadow_r;
    out_data_s  = out_data_r;
    // A frame handed off this cycle empties the output unless replaced below.
    out_valid_s = out_valid_r && !bus.out_ready;
    err_sync_s  = 1'b0;

    case (kind_s)
      KIND_NONE: begin
        cnt_s = cnt_r;
      end
      KIND_STORE: begin
        shadow_s[cnt_r] = bus.in_data;
        cnt_s           = cnt_r + CNT_W'(1);
      end
      KIND_COMPLETE: begin
        out_data_s       = shadow_r;
        out_data_s[LAST] = bus.in_data;
        out_valid_s      = 1'b1;
        cnt_s            = '0;
      end
      KIND_RESYNC: begin
        // The partial frame is abandoned; this word becomes the new lane 0.
        shadow_s[0] = bus.in_data;
        cnt_s       = CNT_W'(1);
        err_sync_s  = 1'b1;
      end
      KIND_DROP: begin
        cnt_s      = '0;
        err_sync_s = 1'b1;
      end
      default: begin
        cnt_s = '0;
      end
    endcase

    if (err_sync_s && (drop_cnt_r != 8'hFF)) begin
      drop_cnt_s = drop_cnt_r + 8'd1;
    end else begin
      drop_cnt_s = drop_cnt_r;
    end
  end

  // State registers; reset clears everything including the data paths.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r       <= '0;
      shadow_r    <= '0;
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
      err_sync_r  <= 1'b0;
      drop_cnt_r  <= 8'd0;
    end else begin
      cnt_r       <= cnt_s;
      shadow_r    <= shadow_s;
      out_data_r  <= out_data_s;
      out_valid_r <= out_valid_s;
      err_sync_r  <= err_sync_s;
      drop_cnt_r  <= drop_cnt_s;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.err_sync  = err_sync_r;
  assign bus.drop_cnt  = drop_cnt_r;

endmodule

// File: doc/deserializer.md
DESERIALIZER -- requirements
Module: deserializer

Interface
REQ-001 The module SHALL have parameter LANES, default 4, meaning the number of words per frame.
REQ-002 The module SHALL have parameter WIDTH, default 16, meaning the bit width of one word.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port in_valid, input, 1 bit: the input word is valid this cycle.
REQ-006 The module SHALL have port in_sof, input, 1 bit: the input word is lane 0 of a frame.
REQ-007 The module SHALL have port in_data, input, WIDTH bits: the input word.
REQ-008 The module SHALL have port in_ready, output, 1 bit: the module accepts the input word this cycle.
REQ-009 The module SHALL have port out_valid, output, 1 bit: out_data holds a complete frame.
REQ-010 The module SHALL have port out_data, output, LANES x WIDTH bits: the assembled frame, lane k in slice k.
REQ-011 The module SHALL have port out_ready, input, 1 bit: the consumer takes the frame this cycle.
REQ-012 The module SHALL have port err_sync, output, 1 bit: one-cycle pulse on a framing error.
REQ-013 The module SHALL have port drop_cnt, output, 8 bits: saturating count of framing errors.

Function
REQ-014 The module SHALL treat a word as accepted only on a cycle where in_valid and in_ready are both 1.
REQ-015 The module SHALL hold a lane counter cnt, range 0..LANES-1, giving the lane index of the next accepted word.
REQ-016 When a word is accepted with cnt < LANES-1, the module SHALL store it in shadow lane cnt and set cnt to cnt+1.
REQ-017 When a word is accepted with cnt = LANES-1, the module SHALL, on the next edge, load out_data from shadow lanes 0..LANES-2 plus in_data as lane LANES-1, set out_valid to 1 and set cnt to 0.
REQ-018 Latency from acceptance of the last lane to out_valid = 1 SHALL be exactly one cycle.
REQ-019 Sustained throughput SHALL be one frame per LANES cycles with no bubbles while out_ready = 1.
REQ-020 in_ready SHALL equal (cnt != LANES-1) OR (out_valid = 0) OR (out_ready = 1), combinationally.
REQ-021 Lanes 0..LANES-2 SHALL be accepted even while the output frame is stalled.
REQ-022 out_valid and out_data SHALL hold stable until a cycle with out_ready = 1.
REQ-023 A frame handoff with out_ready = 1 and completion of a new frame in the same cycle SHALL leave out_valid = 1 with the new frame loaded.
REQ-024 If out_ready = 1 and no frame completes, out_valid SHALL go to 0 on the next edge.
REQ-025 If an accepted word has in_sof = 1 and cnt != 0, the module SHALL discard the partial frame, store the word as lane 0, set cnt to 1 and pulse err_sync.
REQ-026 If an accepted word has in_sof = 0 and cnt = 0, the module SHALL drop the word, leave cnt at 0 and pulse err_sync.
REQ-027 err_sync SHALL be registered, asserted in the cycle after the offending acceptance, for exactly one cycle per error.
REQ-028 drop_cnt SHALL increment by 1 on each err_sync event and saturate at 255.
REQ-029 The module SHALL never reorder lanes and never emit a partial frame.

Reset
REQ-030 Assertion of rst_n = 0 SHALL immediately clear cnt, out_valid, err_sync and drop_cnt to 0, regardless of clk.
REQ-031 out_data and the shadow lanes SHALL reset to 0.
REQ-032 Reset asserted mid-frame SHALL discard the partial frame; after release, the first accepted word SHALL require in_sof = 1.
REQ-033 in_ready SHALL be 1 while in reset and in the first cycle after release.

Structure
REQ-034 A shared package deserializer_pkg SHALL hold the LANES and WIDTH defaults, the word typedef (WIDTH bits) and the frame typedef (LANES x word).
REQ-035 The package SHALL be shared with the serializer so that both ends use an identical frame type.
REQ-036 No sub-module SHALL be required; the counter, shadow lanes, output register and error logic SHALL live in one module.

Verification
REQ-037 Back-to-back frames: feed words 0x1111, 0x2222, 0x3333, 0x4444 with sof on the first, out_ready = 1 -> out_valid one cycle later with out_data = {0x4444, 0x3333, 0x2222, 0x1111}; the next frame follows with no gap.
REQ-038 Backpressure: out_ready = 0 while a second frame arrives -> in_ready drops only at lane 3; the first frame is held intact; raising out_ready delivers both frames in order.
REQ-039 Early sof: sof at lane 0, then sof again at lane 2 -> err_sync pulses once, drop_cnt = 1, and the frame starting at the second sof completes correctly.
REQ-040 Missing sof: 3 words with sof = 0 at idle -> 3 err_sync pulses, drop_cnt = 3, no out_valid.
REQ-041 Reset mid-frame: assert rst_n = 0 after 2 lanes -> out_valid = 0 and cnt = 0 immediately; a clean frame after release is output correctly.
REQ-042 Saturation: 300 framing errors -> drop_cnt = 255 and holds.
